// File: rtl/dp_instr_ctrl_pkg.sv
// Shared types and constants for the ARM32 data-processing controller.
package dp_instr_ctrl_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_WB,
        ST_SKIP
    } state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside a 4-bit NZCV nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // TST/TEQ/CMP/CMN only set flags and never write a register.
    function automatic logic is_compare(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    // Rotated immediate: zero-extended imm8 rotated right by 2*rot.
    function automatic logic [31:0] expand_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] dbl;
        dbl = {24'b0, imm8, 24'b0, imm8} >> {rot, 1'b0};
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/dp_instr_ctrl_if.sv
// Instruction valid/ready handshake between the instruction source and the controller.
interface dp_instr_ctrl_if;
    import dp_instr_ctrl_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/dp_instr_ctrl_cond_eval.sv
// ARM condition-code check of a cond field against the NZCV flags.
module cond_eval
    import dp_instr_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Full EQ..AL table; NV never passes.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_instr_ctrl.sv
// Multi-cycle controller for the ARM32 data-processing datapath; owns the NZCV status register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | instr_ready high, waiting for a valid instruction
// LOAD    | operand registers load (en_ab), immediate presented
// EXEC    | EXEC_LAT ALU cycles, en_c and flag sample on the last one
// WB      | register write (non-compare), flag update, retired pulse
// SKIP    | one dead cycle after a failed condition or non-DP encoding
module dp_instr_ctrl
    import dp_instr_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int EXEC_LAT   = 1,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dp_instr_ctrl_if.slave        in_if,
    input  logic [3:0]            alu_flags,
    output logic [REG_ADDR_W-1:0] ra_addr,
    output logic [REG_ADDR_W-1:0] rb_addr,
    output logic                  en_ab,
    output logic                  sel_imm,
    output logic [DATA_W-1:0]     imm_out,
    output logic [3:0]            alu_op,
    output logic                  en_c,
    output logic                  w_en,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [31:0]           status_out,
    output logic                  retired,
    output logic                  skipped,
    output logic                  undef
);

    localparam int CNT_W = 3;

    state_t     state;
    logic [CNT_W-1:0] exec_cnt;
    logic       ready_q;
    logic [3:0] nzcv;
    logic [3:0] flags_q;
    logic [3:0] rn_q, rm_q, rd_q, op_q, rot_q;
    logic [7:0] imm8_q;
    logic       s_q, i_q;
    logic       cond_pass;

    cond_eval u_cond_eval (
        .cond (in_if.instr[31:28]),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    // Datapath fields come from the latched copy so the source may move on after accept.
    assign in_if.instr_ready = ready_q;
    assign ra_addr    = REG_ADDR_W'(rn_q);
    assign rb_addr    = REG_ADDR_W'(rm_q);
    assign w_addr     = REG_ADDR_W'(rd_q);
    assign alu_op     = op_q;
    assign sel_imm    = i_q;
    assign imm_out    = DATA_W'(expand_imm(imm8_q, rot_q));
    assign status_out = {nzcv, 28'b0};

    // Sequencer: accept, load, execute, write back or skip, with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            exec_cnt <= '0;
            ready_q  <= 1'b1;
            nzcv     <= 4'b0;
            flags_q  <= 4'b0;
            en_ab    <= 1'b0;
            en_c     <= 1'b0;
            w_en     <= 1'b0;
            retired  <= 1'b0;
            skipped  <= 1'b0;
            undef    <= 1'b0;
            rn_q     <= 4'b0;
            rm_q     <= 4'b0;
            rd_q     <= 4'b0;
            op_q     <= 4'b0;
            rot_q    <= 4'b0;
            imm8_q   <= 8'b0;
            s_q      <= 1'b0;
            i_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_if.instr_valid && ready_q) begin
                        ready_q <= 1'b0;
                        i_q     <= in_if.instr[25];
                        op_q    <= in_if.instr[24:21];
                        s_q     <= in_if.instr[20];
                        rn_q    <= in_if.instr[19:16];
                        rd_q    <= in_if.instr[15:12];
                        rot_q   <= in_if.instr[11:8];
                        imm8_q  <= in_if.instr[7:0];
                        rm_q    <= in_if.instr[3:0];
                        if (in_if.instr[27:26] != 2'b00) begin
                            state <= ST_SKIP;
                            undef <= 1'b1;
                        end else if (!cond_pass) begin
                            state   <= ST_SKIP;
                            skipped <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            en_ab <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    en_ab    <= 1'b0;
                    state    <= ST_EXEC;
                    exec_cnt <= CNT_W'(EXEC_LAT - 1);
                    en_c     <= (EXEC_LAT == 1);
                end
                ST_EXEC: begin
                    if (exec_cnt == '0) begin
                        en_c    <= 1'b0;
                        flags_q <= alu_flags;
                        w_en    <= !is_compare(op_q);
                        retired <= 1'b1;
                        state   <= ST_WB;
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                        en_c     <= (exec_cnt == CNT_W'(1));
                    end
                end
                ST_WB: begin
                    w_en    <= 1'b0;
                    retired <= 1'b0;
                    if (s_q || is_compare(op_q)) begin
                        nzcv <= flags_q;
                    end
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_SKIP: begin
                    skipped <= 1'b0;
                    undef   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_instr_ctrl.sv
// Directed bench for dp_instr_ctrl: one-cycle and three-cycle execute builds plus cond_eval table.
module tb_dp_instr_ctrl;
    import dp_instr_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // EXEC_LAT = 1 instance
    logic        rst_a;
    logic [3:0]  alu_a;
    logic [3:0]  a_ra, a_rb, a_waddr, a_op;
    logic        a_en_ab, a_sel_imm, a_en_c, a_w_en, a_ret, a_skip, a_undef;
    logic [31:0] a_imm, a_status;
    dp_instr_ctrl_if if_a ();

    dp_instr_ctrl #(.DATA_W(32), .EXEC_LAT(1), .REG_ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .in_if(if_a.slave), .alu_flags(alu_a),
        .ra_addr(a_ra), .rb_addr(a_rb), .en_ab(a_en_ab), .sel_imm(a_sel_imm),
        .imm_out(a_imm), .alu_op(a_op), .en_c(a_en_c), .w_en(a_w_en),
        .w_addr(a_waddr), .status_out(a_status), .retired(a_ret),
        .skipped(a_skip), .undef(a_undef)
    );

    // EXEC_LAT = 3 instance
    logic        rst_b;
    logic [3:0]  alu_b;
    logic [3:0]  b_ra, b_rb, b_waddr, b_op;
    logic        b_en_ab, b_sel_imm, b_en_c, b_w_en, b_ret, b_skip, b_undef;
    logic [31:0] b_imm, b_status;
    dp_instr_ctrl_if if_b ();

    dp_instr_ctrl #(.DATA_W(32), .EXEC_LAT(3), .REG_ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .in_if(if_b.slave), .alu_flags(alu_b),
        .ra_addr(b_ra), .rb_addr(b_rb), .en_ab(b_en_ab), .sel_imm(b_sel_imm),
        .imm_out(b_imm), .alu_op(b_op), .en_c(b_en_c), .w_en(b_w_en),
        .w_addr(b_waddr), .status_out(b_status), .retired(b_ret),
        .skipped(b_skip), .undef(b_undef)
    );

    // Standalone condition evaluator
    logic [3:0] ce_cond, ce_nzcv;
    logic       ce_pass;
    cond_eval u_ce (.cond(ce_cond), .nzcv(ce_nzcv), .pass(ce_pass));

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic [31:0] word);
        if_a.instr_valid = 1'b1;
        if_a.instr       = word;
        step();
        if_a.instr_valid = 1'b0;
        if_a.instr       = 32'h0;
    endtask

    task automatic issue_b(input logic [31:0] word);
        if_b.instr_valid = 1'b1;
        if_b.instr       = word;
        step();
        if_b.instr_valid = 1'b0;
        if_b.instr       = 32'h0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        step(); step();
        checks++; if (a_status !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 00000000", a_status); end
        checks++; if ({a_en_ab, a_en_c, a_w_en, a_ret, a_skip, a_undef} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", {a_en_ab, a_en_c, a_w_en, a_ret, a_skip, a_undef}); end
        rst_a = 1'b0; rst_b = 1'b0;
        step();
        checks++; if (if_a.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b exp 1", if_a.instr_ready); end
        checks++; if (if_b.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %b exp 1", if_b.instr_ready); end
    endtask

    task automatic test_mov_imm();
        alu_a = 4'hF;
        issue_a(32'hE3A034FF);
        checks++; if (a_en_ab !== 1'b1) begin errors++; $display("FAIL mov_en_ab got %b exp 1", a_en_ab); end
        checks++; if (a_sel_imm !== 1'b1) begin errors++; $display("FAIL mov_sel_imm got %b exp 1", a_sel_imm); end
        checks++; if (a_imm !== 32'hFF000000) begin errors++; $display("FAIL mov_imm got %h exp ff000000", a_imm); end
        checks++; if (a_op !== OP_MOV) begin errors++; $display("FAIL mov_alu_op got %h exp d", a_op); end
        checks++; if (if_a.instr_ready !== 1'b0) begin errors++; $display("FAIL mov_ready_load got %b exp 0", if_a.instr_ready); end
        checks++; if (a_en_c !== 1'b0) begin errors++; $display("FAIL mov_en_c_early got %b exp 0", a_en_c); end
        step();
        checks++; if ({a_en_ab, a_en_c, a_w_en} !== 3'b010) begin errors++; $display("FAIL mov_exec got %b exp 010", {a_en_ab, a_en_c, a_w_en}); end
        step();
        checks++; if ({a_en_c, a_w_en, a_ret} !== 3'b011) begin errors++; $display("FAIL mov_wb got %b exp 011", {a_en_c, a_w_en, a_ret}); end
        checks++; if (a_waddr !== 4'd3) begin errors++; $display("FAIL mov_w_addr got %0d exp 3", a_waddr); end
        step();
        checks++; if ({if_a.instr_ready, a_w_en, a_ret} !== 3'b100) begin errors++; $display("FAIL mov_idle got %b exp 100", {if_a.instr_ready, a_w_en, a_ret}); end
        checks++; if (a_status !== 32'h0) begin errors++; $display("FAIL mov_status got %h exp 00000000", a_status); end
    endtask

    task automatic test_cmp_cond();
        alu_a = 4'b0100;
        issue_a(32'hE1500001);
        checks++; if ({a_ra, a_rb, a_sel_imm} !== {4'd0, 4'd1, 1'b0}) begin errors++; $display("FAIL cmp_load got %h/%h/%b exp 0/1/0", a_ra, a_rb, a_sel_imm); end
        step();
        step();
        checks++; if ({a_w_en, a_ret} !== 2'b01) begin errors++; $display("FAIL cmp_wb got %b exp 01", {a_w_en, a_ret}); end
        step();
        checks++; if (a_status !== 32'h40000000) begin errors++; $display("FAIL cmp_status got %h exp 40000000", a_status); end
        issue_a(32'h13A00001);
        checks++; if ({a_skip, a_undef, a_en_ab, a_w_en, if_a.instr_ready} !== 5'b10000) begin errors++; $display("FAIL movne_skip got %b exp 10000", {a_skip, a_undef, a_en_ab, a_w_en, if_a.instr_ready}); end
        step();
        checks++; if ({a_skip, if_a.instr_ready} !== 2'b01) begin errors++; $display("FAIL movne_after got %b exp 01", {a_skip, if_a.instr_ready}); end
        issue_a(32'h03A00001);
        checks++; if (a_en_ab !== 1'b1) begin errors++; $display("FAIL moveq_en_ab got %b exp 1", a_en_ab); end
        step();
        step();
        checks++; if ({a_w_en, a_ret, a_waddr} !== {2'b11, 4'd0}) begin errors++; $display("FAIL moveq_wb got %b/%0d exp 11/0", {a_w_en, a_ret}, a_waddr); end
        step();
        checks++; if (a_status !== 32'h40000000) begin errors++; $display("FAIL moveq_status got %h exp 40000000", a_status); end
    endtask

    task automatic test_exec_lat3();
        alu_b = 4'b0000;
        issue_b(32'hE0900000);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (if_b.instr_ready !== 1'b0) begin errors++; $display("FAIL lat3_ready cyc %0d got %b exp 0", k, if_b.instr_ready); end
            checks++; if ({b_en_ab, b_en_c, b_w_en, b_ret} !== {k == 1, k == 4, k == 5, k == 5}) begin errors++; $display("FAIL lat3_strobes cyc %0d got %b exp %b", k, {b_en_ab, b_en_c, b_w_en, b_ret}, {k == 1, k == 4, k == 5, k == 5}); end
            alu_b = (k == 4) ? 4'b1010 : 4'b0000;
            step();
        end
        checks++; if (if_b.instr_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready_after got %b exp 1", if_b.instr_ready); end
        checks++; if (b_status !== 32'hA0000000) begin errors++; $display("FAIL lat3_status got %h exp a0000000", b_status); end
    endtask

    task automatic test_back_to_back();
        int         n_wr = 0;
        int         n_ld = 0;
        logic [3:0] got [0:3];
        for (int i = 0; i < 16; i++) begin
            if (a_w_en === 1'b1) begin
                if (n_wr < 4) got[n_wr] = a_waddr;
                n_wr++;
            end
            if (a_en_ab === 1'b1) n_ld++;
            if (i < 12) begin
                if_a.instr_valid = 1'b1;
                if_a.instr       = 32'hE3A00000 | (32'(i + 1) << 12) | 32'(i + 1);
            end else begin
                if_a.instr_valid = 1'b0;
                if_a.instr       = 32'h0;
            end
            step();
        end
        checks++; if (n_ld !== 3) begin errors++; $display("FAIL b2b_loads got %0d exp 3", n_ld); end
        checks++; if (n_wr !== 3) begin errors++; $display("FAIL b2b_writes got %0d exp 3", n_wr); end
        if (n_wr >= 3) begin
            checks++; if ({got[0], got[1], got[2]} !== {4'd1, 4'd5, 4'd9}) begin errors++; $display("FAIL b2b_addrs got %0d,%0d,%0d exp 1,5,9", got[0], got[1], got[2]); end
        end
    endtask

    task automatic test_skip_undef();
        issue_a(32'hF3A00001);
        checks++; if ({a_skip, a_undef, a_en_ab, a_en_c, a_w_en, if_a.instr_ready} !== 6'b100000) begin errors++; $display("FAIL nv_skip got %b exp 100000", {a_skip, a_undef, a_en_ab, a_en_c, a_w_en, if_a.instr_ready}); end
        step();
        checks++; if ({a_skip, if_a.instr_ready} !== 2'b01) begin errors++; $display("FAIL nv_after got %b exp 01", {a_skip, if_a.instr_ready}); end
        issue_a(32'hE5900000);
        checks++; if ({a_skip, a_undef, a_en_ab, a_en_c, a_w_en, if_a.instr_ready} !== 6'b010000) begin errors++; $display("FAIL ldr_undef got %b exp 010000", {a_skip, a_undef, a_en_ab, a_en_c, a_w_en, if_a.instr_ready}); end
        step();
        checks++; if ({a_undef, if_a.instr_ready} !== 2'b01) begin errors++; $display("FAIL ldr_after got %b exp 01", {a_undef, if_a.instr_ready}); end
        checks++; if (a_status !== 32'h40000000) begin errors++; $display("FAIL skip_status got %h exp 40000000", a_status); end
    endtask

    task automatic test_reset_mid_exec();
        alu_b = 4'hF;
        issue_b(32'hE0900000);
        step();
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        checks++; if (if_b.instr_ready !== 1'b1) begin errors++; $display("FAIL rstx_ready got %b exp 1", if_b.instr_ready); end
        checks++; if (b_status !== 32'h0) begin errors++; $display("FAIL rstx_status got %h exp 00000000", b_status); end
        checks++; if ({b_en_c, b_w_en, b_ret} !== 3'b000) begin errors++; $display("FAIL rstx_strobes got %b exp 000", {b_en_c, b_w_en, b_ret}); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (b_w_en !== 1'b0) begin errors++; $display("FAIL rstx_no_write cyc %0d got %b exp 0", k, b_w_en); end
        end
        checks++; if (b_status !== 32'h0) begin errors++; $display("FAIL rstx_status_late got %h exp 00000000", b_status); end
    endtask

    task automatic test_cond_eval();
        logic [8:0] vec [0:19];
        vec = '{
            {4'h0, 4'b0100, 1'b1}, {4'h1, 4'b0100, 1'b0}, {4'h2, 4'b0010, 1'b1}, {4'h3, 4'b0010, 1'b0},
            {4'h4, 4'b1000, 1'b1}, {4'h5, 4'b1000, 1'b0}, {4'h6, 4'b0001, 1'b1}, {4'h7, 4'b0000, 1'b1},
            {4'h8, 4'b0010, 1'b1}, {4'h9, 4'b0010, 1'b0}, {4'hA, 4'b1001, 1'b1}, {4'hB, 4'b1000, 1'b1},
            {4'hC, 4'b0000, 1'b1}, {4'hD, 4'b1000, 1'b1}, {4'hE, 4'b0000, 1'b1}, {4'hF, 4'b1111, 1'b0},
            {4'h8, 4'b0110, 1'b0}, {4'hC, 4'b0100, 1'b0}, {4'hA, 4'b1000, 1'b0}, {4'hD, 4'b0000, 1'b0}
        };
        for (int i = 0; i < 20; i++) begin
            ce_cond = vec[i][8:5];
            ce_nzcv = vec[i][4:1];
            #1;
            checks++; if (ce_pass !== vec[i][0]) begin errors++; $display("FAIL cond_eval cond %h nzcv %b got %b exp %b", ce_cond, ce_nzcv, ce_pass, vec[i][0]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        alu_a = 4'h0; alu_b = 4'h0;
        if_a.instr_valid = 1'b0; if_a.instr = 32'h0;
        if_b.instr_valid = 1'b0; if_b.instr = 32'h0;
        ce_cond = 4'h0; ce_nzcv = 4'h0;
        test_reset();
        test_mov_imm();
        test_cmp_cond();
        test_exec_lat3();
        test_back_to_back();
        test_skip_undef();
        test_reset_mid_exec();
        test_cond_eval();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_instr_ctrl.md
Name: dp_instr_ctrl

Overview:
- Parametrised multi-cycle controller for the ARM32 data-processing datapath.
- Successor to the fixed four-clock, reset-stepped control. Instructions now arrive on a valid/ready handshake.
- Adds condition-code evaluation against held NZCV flags, a configurable execute latency, rotated-immediate expansion, and S-bit/compare flag update.
- Sits between the instruction source and the register file/ALU datapath; owns the status register.

Parameters:
DATA_W, 32, datapath and immediate width (>=32)
EXEC_LAT, 1, ALU cycles in EXEC state (1..8)
REG_ADDR_W, 4, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instr holds a valid instruction
instr  in  32  ARM data-processing encoding
alu_flags  in  4  NZCV from ALU, valid during last EXEC cycle
instr_ready  out  1  controller idle, can accept (replaces waiting)
ra_addr  out  REG_ADDR_W  read port A address (Rn)
rb_addr  out  REG_ADDR_W  read port B address (Rm)
en_ab  out  1  load A/B operand registers
sel_imm  out  1  B operand = imm_out
imm_out  out  DATA_W  expanded immediate, zero-extended
alu_op  out  4  opcode [24:21]
en_c  out  1  load ALU result register
w_en  out  1  register-file write strobe
w_addr  out  REG_ADDR_W  write address (Rd)
status_out  out  32  NZCV in [31:28], rest 0
retired  out  1  one-cycle pulse, instruction completed
skipped  out  1  one-cycle pulse, condition failed or NV
undef  out  1  one-cycle pulse, non-DP encoding

Behaviour:
- States: IDLE, LOAD, EXEC, WB, SKIP.
- Reset (rst=1 at edge):
  - state=IDLE, status_out=0, exec counter=0.
  - All strobes/pulses 0; instr_ready=1 in the cycle after reset.
  - Reset mid-instruction abandons it: no write, no flag update.
- IDLE:
  - instr_ready=1; accept when instr_valid && instr_ready; latch instr.
  - Decode uses the latched copy; instr may change after acceptance.
- Acceptance branch:
  - If instr[27:26]!=00 -> SKIP, with undef pulse.
  - Else if the cond check on instr[31:28] vs current status_out flags fails -> SKIP, with skipped pulse.
  - Else -> LOAD.
- Condition codes: full ARM set EQ..AL. Cond 1111 (NV) always fails.
- LOAD (1 cycle):
  - en_ab=1; ra_addr=Rn[19:16]; rb_addr=Rm[3:0].
  - sel_imm=I[25]; imm_out=ROR(zero-extended imm8[7:0], 2*rot[11:8]) within 32 bits.
  - Register-shifted operands are unsupported; shift fields are ignored.
- EXEC (EXEC_LAT cycles):
  - alu_op held.
  - en_c=1 on the last cycle only; alu_flags sampled on that cycle.
- WB (1 cycle):
  - w_en=1, w_addr=Rd, except for TST/TEQ/CMP/CMN (1000-1011), which never write.
  - status_out[31:28] <= sampled flags if S[20]=1 or op is a compare. Otherwise flags are unchanged.
  - retired=1. Next state IDLE.
- SKIP (1 cycle): no en_ab/en_c/w_en, no flag change; then IDLE.
- Timing:
  - Accepted DP instruction occupies 2+EXEC_LAT cycles after the accept edge.
  - Next accept is possible 3+EXEC_LAT cycles after the previous one.
  - Skip/undef: next accept 2 cycles later.
- instr_ready=0 in every state except IDLE. No accept while busy, regardless of instr_valid.
- Flags updated in WB are visible to the condition check of the next accepted instruction (no hazard).
- All outputs registered or decoded from state only. Nothing combinational from instr_valid except the accept itself.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants (AND..MVN)
  - cond code constants
  - NZCV bit indices
  - is_compare(op) function
- One sub-module, cond_eval: combinational cond[3:0] + NZCV -> pass. Unit-testable on its own.

Test Plan:
1. Reset, then MOV R3,#0x0FF with rot=4 (instr 0xE3A034FF): accept, then en_ab with imm_out=0xFF000000, sel_imm=1. en_c 1 cycle later; next cycle w_en=1, w_addr=3, retired=1; status unchanged.
2. CMP (0xE1500001) with alu_flags=0100: no w_en; status_out=0x40000000. Then MOVNE R0,#1 (0x13A00001) -> skipped=1, no w_en. MOVEQ (0x03A00001) -> retired, w_en=1.
3. EXEC_LAT=3 build, ADDS R0,R0,R0 (0xE0900000): en_c exactly on the 3rd EXEC cycle; flags latched; instr_ready low for 5 cycles after accept.
4. Back-to-back instr_valid held high with changing instr: accepts only in IDLE; each latched instruction executes exactly once.
5. Cond NV (0xF3A00001) and LDR-class encoding (0xE5900000): skipped and undef pulses respectively, 1 busy cycle each, no strobes.
6. Assert rst during EXEC of ADDS: next cycle state IDLE, w_en never asserted, status_out=0, instr_ready=1.
